// File: rtl/toggle_handshake_rx.sv
// ---------------------------------------------------------------------------
// toggle_handshake_rx
//
// Receiving end of a two-phase (toggle) request/acknowledge link. The sender
// flips req_tgl once per request and holds req_data stable until ack_tgl
// flips back. This block synchronises req_tgl into the clk domain and spots
// each level change. It then captures req_data and presents the word on a
// valid/ready port. When the consumer takes the word, it flips ack_tgl.
//
// Parameters:
//   SYNC_STAGES - flops in the req_tgl synchroniser (2 or more)
//   DATA_W      - payload width
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous reset, active-high
//   req_tgl     - request toggle from the sender (asynchronous to clk)
//   req_data    - request payload, stable by protocol while a request is open
//   ack_tgl     - acknowledge toggle back to the sender
//   out_data    - captured word
//   out_valid   - out_data holds an unconsumed word
//   out_ready   - consumer accepts out_data when out_valid is high
//   busy        - same as out_valid
//   overrun_cnt - (TOGGLE_HANDSHAKE_RX_OVERRUN_EN only) saturating count of
//                 req_tgl changes seen while a word was still being held
//
// Optional feature macro: TOGGLE_HANDSHAKE_RX_OVERRUN_EN
// ---------------------------------------------------------------------------
module toggle_handshake_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_EN
    ,
    output logic [7:0]        overrun_cnt
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   req_last;
    logic                   det;
    logic [0:0]             state;

    // Plain shift chain with nothing between the stages, so every stage can
    // settle out of metastability. req_data is not synchronised: the protocol
    // keeps it stable long before the toggle reaches s.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], req_tgl};
        end
    end

    assign s   = sync[SYNC_STAGES-1];
    assign det = (s != req_last);

    // Two-state handshake. req_last is updated only on capture. A toggle that
    // arrives while a word is held is therefore evaluated on return to IDLE,
    // and an even number of such toggles cancels out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_last <= 1'b0;
            ack_tgl  <= 1'b0;
            out_data <= '0;
        end else if (state == IDLE) begin
            if (det) begin
                out_data <= req_data;
                req_last <= s;
                state    <= HOLD;
            end
        end else begin
            if (out_ready) begin
                ack_tgl <= ~ack_tgl;
                state   <= IDLE;
            end
        end
    end

    // The state flop itself is the valid flag, so busy and out_valid are
    // registered without any extra flop.
    assign out_valid = (state == HOLD);
    assign busy      = out_valid;

`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_EN
    logic s_prev;

    // Count every change of s that arrives while a word is still held. These
    // are sender protocol violations that the handshake itself cannot report.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev      <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            s_prev <= s;
            if ((state == HOLD) && (s != s_prev) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// ---------------------------------------------------------------------------
// tb_toggle_handshake_rx
//
// Scoreboard bench for toggle_handshake_rx (SYNC_STAGES=2, DATA_W=8).
// Stimulus code acts as the sender: every word it sends is queued as
// expected. A monitor runs on each falling edge. It pops and compares a word
// whenever the DUT hands one over. It also tracks the acknowledge level as
// the parity of words handed over since the last reset.
// Build with +define+TOGGLE_HANDSHAKE_RX_OVERRUN_EN to exercise overrun_cnt.
// ---------------------------------------------------------------------------
module tb_toggle_handshake_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       ack_tgl;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_EN
    logic [7:0] overrun_cnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] expQ[$];
    logic       ackModel    = 1'b0;
    logic       holdActive  = 1'b0;
    logic [7:0] heldData    = 8'h00;
    logic       monitorOn   = 1'b0;

    toggle_handshake_rx #(
        .SYNC_STAGES(2),
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_tgl(req_tgl),
        .req_data(req_data),
        .ack_tgl(ack_tgl),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge. Outputs are sampled
    // on the falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // The sender flips req_tgl for a new word, and the word becomes expected.
    task automatic applyStimulus(input logic [7:0] data);
        req_data = data;
        req_tgl  = ~req_tgl;
        expQ.push_back(data);
    endtask

    task automatic waitAck(input logic oldAck, input int limit);
        int n = 0;
        while (ack_tgl === oldAck && n < limit) begin
            tick();
            n++;
        end
        if (ack_tgl === oldAck) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ack_timeout: got 0x%0h expected 0x%0h", ack_tgl, ~oldAck);
        end
    endtask

    task automatic waitValid(input int limit);
        int n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL valid_timeout: got 0x%0h expected 0x1", out_valid);
        end
        tick();
    endtask

    // Monitor: a word is handed over when valid and ready are both high at
    // the sampling point. The acknowledge level then flips at the next edge.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("busy_eq_valid", {31'd0, busy}, {31'd0, out_valid});
            checkOutput("ack_level", {31'd0, ack_tgl}, {31'd0, ackModel});
            if (rst) begin
                ackModel   = 1'b0;
                holdActive = 1'b0;
            end else if (out_valid) begin
                if (holdActive)
                    checkOutput("data_stable", {24'd0, out_data}, {24'd0, heldData});
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected_word: got 0x%0h expected none", out_data);
                    end else begin
                        checkOutput("word", {24'd0, out_data}, {24'd0, expQ.pop_front()});
                    end
                    ackModel   = ~ackModel;
                    holdActive = 1'b0;
                end else begin
                    holdActive = 1'b1;
                    heldData   = out_data;
                end
            end
        end
    end

    initial begin
        int sent;
        int cycles;
        logic waiting;
        logic ackAtSend;

        rst       = 1'b1;
        req_tgl   = 1'b0;
        req_data  = 8'h00;
        out_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack", {31'd0, ack_tgl}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, out_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_EN
        checkOutput("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
`endif
        tick();
        rst       = 1'b0;
        monitorOn = 1'b1;

        // Single transfer with ready high: valid after edge k+2, done at k+3.
        out_ready = 1'b1;
        applyStimulus(8'hA5);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("single_data", {24'd0, out_data}, 32'hA5);
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_done", {31'd0, out_valid}, 32'd0);
        checkOutput("single_ack", {31'd0, ack_tgl}, 32'd1);
        tick();

        // Backpressure: the word is held for five cycles.
        out_ready = 1'b0;
        applyStimulus(8'hA5);
        waitValid(10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_data", {24'd0, out_data}, 32'hA5);
            checkOutput("bp_ack", {31'd0, ack_tgl}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_release_ack", {31'd0, ack_tgl}, 32'd0);
        tick();

        // Back-to-back words in both toggle directions.
        applyStimulus(8'h3C);
        waitAck(1'b0, 20);
        checkOutput("b2b_ack1", {31'd0, ack_tgl}, 32'd1);
        applyStimulus(8'hC3);
        waitAck(1'b1, 20);
        checkOutput("b2b_ack0", {31'd0, ack_tgl}, 32'd0);
        @(negedge clk);
        checkOutput("b2b_idle", {31'd0, out_valid}, 32'd0);
        tick();

        // Reset while holding: the word is dropped, then captured again.
        out_ready = 1'b0;
        applyStimulus(8'h5A);
        waitValid(10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_ack", {31'd0, ack_tgl}, 32'd0);
        tick();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("recap_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("recap_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("recap_data", {24'd0, out_data}, 32'h5A);
        tick();
        out_ready = 1'b1;
        waitAck(1'b0, 10);

        // Overrun: two extra toggles while held cancel and are never captured.
        out_ready = 1'b0;
        applyStimulus(8'h77);
        waitValid(10);
        req_tgl = ~req_tgl;
        repeat (4) tick();
        req_tgl = ~req_tgl;
        repeat (4) tick();
        @(negedge clk);
        checkOutput("ovr_still_held", {24'd0, out_data}, 32'h77);
`ifdef TOGGLE_HANDSHAKE_RX_OVERRUN_EN
        checkOutput("ovr_count", {24'd0, overrun_cnt}, 32'd2);
`endif
        tick();
        out_ready = 1'b1;
        waitAck(1'b1, 10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("ovr_no_capture", {31'd0, out_valid}, 32'd0);
            tick();
        end

        // Randomised traffic with a random consumer.
        sent      = 0;
        cycles    = 0;
        waiting   = 1'b0;
        ackAtSend = ack_tgl;
        while ((sent < 40 || waiting) && cycles < 4000) begin
            tick();
            cycles++;
            out_ready = 1'($urandom_range(0, 1));
            if (waiting && ack_tgl !== ackAtSend)
                waiting = 1'b0;
            if (!waiting && sent < 40 && $urandom_range(0, 3) == 0) begin
                ackAtSend = ack_tgl;
                applyStimulus(8'($urandom));
                waiting = 1'b1;
                sent++;
            end
        end
        checkOutput("random_finished", {31'd0, waiting}, 32'd0);
        out_ready = 1'b1;
        repeat (8) tick();
        checkOutput("queue_empty", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
